// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the M-stage memory access unit: op encodings, exception codes, FSM states.
package mem_access_unit_pkg;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_BU = 3'b001;
    localparam logic [2:0] OP_B  = 3'b010;
    localparam logic [2:0] OP_HU = 3'b011;
    localparam logic [2:0] OP_H  = 3'b100;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_store_align.sv
// Byte-lane steering for one access: byte enables, replicated store data, effective offset, address check.
// Alignment exceptions exist only when MEM_ALIGN_EXC_EN is defined.
module mem_store_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  a,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [1:0]  a_eff,
    output logic        addr_exc
);

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        a_eff     = 2'b00;
        addr_exc  = 1'b0;
        case (op)
            OP_BU, OP_B: begin
                be        = 4'b0001 << a;
                wdata_rep = {4{wdata[7:0]}};
                a_eff     = a;
            end
            OP_HU, OP_H: begin
                be        = a[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
`ifdef MEM_ALIGN_EXC_EN
                a_eff     = a;
                addr_exc  = a[0];
`else
                // Without alignment checks the halfword lane is chosen by a[1] alone.
                a_eff     = {a[1], 1'b0};
`endif
            end
            default: begin
`ifdef MEM_ALIGN_EXC_EN
                a_eff     = a;
                addr_exc  = (a != 2'b00);
`endif
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store front end: one req/ack bus transaction per access, stall, exceptions, raw load hand-off.
// Optional MEM_ALIGN_EXC_EN enables halfword/word misalignment exceptions (see mem_store_align).
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        we_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic [1:0]  rd_a_o,
    output logic [2:0]  rd_op_o,
    output logic        exc_o,
    output logic [4:0]  exc_code_o
);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic             killed;
    logic [1:0]       ld_a;
    logic [2:0]       ld_op;

    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic [1:0]       a_eff;
    logic             addr_exc;

    logic             accept;
    logic             reject;
    logic             timeout;

    mem_store_align u_align (
        .op        (op_i),
        .a         (addr_i[1:0]),
        .wdata     (wdata_i),
        .be        (be),
        .wdata_rep (wdata_rep),
        .a_eff     (a_eff),
        .addr_exc  (addr_exc)
    );

    assign accept  = (state == S_IDLE) && valid_i && !flush_i && !addr_exc;
    assign reject  = (state == S_IDLE) && valid_i && !flush_i && addr_exc;
    assign timeout = (state == S_WAIT) && !bus_ack_i && (cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        case (state)
            S_IDLE: begin
                stall_o = accept;
                if (accept) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_o = !bus_ack_i;
                // Ack beats a coincident timeout, so it is tested first.
                if (bus_ack_i || timeout) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= '0;
            killed      <= 1'b0;
            ld_a        <= '0;
            ld_op       <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            rd_a_o      <= '0;
            rd_op_o     <= '0;
            exc_o       <= 1'b0;
            exc_code_o  <= '0;
        end else begin
            rd_valid_o <= 1'b0;
            exc_o      <= 1'b0;
            exc_code_o <= '0;
            if (accept) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= we_i;
                bus_addr_o  <= {addr_i[31:2], 2'b00};
                bus_be_o    <= we_i ? be : 4'b0000;
                bus_wdata_o <= wdata_rep;
                ld_a        <= a_eff;
                ld_op       <= op_i;
                cnt         <= '0;
                killed      <= 1'b0;
            end
            if (reject) begin
                exc_o      <= 1'b1;
                exc_code_o <= we_i ? EXC_ADES : EXC_ADEL;
            end
            if (state == S_WAIT) begin
                if (flush_i) begin
                    killed <= 1'b1;
                end
                if (bus_ack_i) begin
                    bus_req_o <= 1'b0;
                    // A flushed load still completes on the bus but never reaches the extension stage.
                    if (!bus_we_o && !killed && !flush_i) begin
                        rd_valid_o <= 1'b1;
                        rd_data_o  <= bus_rdata_i;
                        rd_a_o     <= ld_a;
                        rd_op_o    <= ld_op;
                    end
                end else if (timeout) begin
                    bus_req_o  <= 1'b0;
                    exc_o      <= 1'b1;
                    exc_code_o <= EXC_DBE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES=4); follows MEM_ALIGN_EXC_EN if defined.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        we_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic [1:0]  rd_a_o;
    logic [2:0]  rd_op_o;
    logic        exc_o;
    logic [4:0]  exc_code_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_i     (valid_i),
        .we_i        (we_i),
        .op_i        (op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .flush_i     (flush_i),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .stall_o     (stall_o),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .rd_a_o      (rd_a_o),
        .rd_op_o     (rd_op_o),
        .exc_o       (exc_o),
        .exc_code_o  (exc_code_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned delay;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        logic [1:0]  ra;
    } vec_t;

    vec_t vecs[9];

    task automatic drive(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        valid_i = 1'b1;
        we_i    = we;
        op_i    = op;
        addr_i  = addr;
        wdata_i = wdata;
        flush_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int stall_cnt;
        stall_cnt = 0;
        @(negedge clk);
        drive(v.we, v.op, v.addr, v.wdata);
        bus_ack_i = 1'b0;
        #1 if (stall_o) stall_cnt++;
        @(negedge clk);
        check($sformatf("v%0d_req", idx), bus_req_o, 1);
        check($sformatf("v%0d_we", idx), bus_we_o, v.we);
        check($sformatf("v%0d_addr", idx), bus_addr_o, v.baddr);
        check($sformatf("v%0d_be", idx), bus_be_o, v.be);
        if (v.we) check($sformatf("v%0d_wdata", idx), bus_wdata_o, v.bwdata);
        for (int k = 0; k < int'(v.delay); k++) begin
            #1 if (stall_o) stall_cnt++;
            @(negedge clk);
            check($sformatf("v%0d_req_held", idx), bus_req_o, 1);
            check($sformatf("v%0d_addr_held", idx), bus_addr_o, v.baddr);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = v.rdata;
        #1 check($sformatf("v%0d_stall_ack", idx), stall_o, 0);
        @(negedge clk);
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        valid_i     = 1'b0;
        check($sformatf("v%0d_req_drop", idx), bus_req_o, 0);
        check($sformatf("v%0d_rd_valid", idx), rd_valid_o, !v.we);
        check($sformatf("v%0d_exc", idx), exc_o, 0);
        check($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.delay + 1);
        if (!v.we) begin
            check($sformatf("v%0d_rd_data", idx), rd_data_o, v.rdata);
            check($sformatf("v%0d_rd_a", idx), rd_a_o, v.ra);
            check($sformatf("v%0d_rd_op", idx), rd_op_o, v.op);
        end
        @(negedge clk);
        check($sformatf("v%0d_rd_valid_pulse", idx), rd_valid_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, OP_W,  32'h100, 32'h12345678, 32'h0,        3, 4'b1111, 32'h12345678, 32'h100, 2'd0};
        vecs[1] = '{1'b1, OP_BU, 32'h103, 32'h000000AB, 32'h0,        1, 4'b1000, 32'hABABABAB, 32'h100, 2'd0};
        vecs[2] = '{1'b1, OP_HU, 32'h206, 32'h0000BEEF, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 32'h204, 2'd0};
        vecs[3] = '{1'b1, OP_B,  32'h010, 32'h123456CD, 32'h0,        0, 4'b0001, 32'hCDCDCDCD, 32'h010, 2'd0};
        vecs[4] = '{1'b1, OP_H,  32'h008, 32'h99991357, 32'h0,        2, 4'b0011, 32'h13571357, 32'h008, 2'd0};
        vecs[5] = '{1'b0, OP_H,  32'h202, 32'h0,        32'h80010000, 2, 4'b0000, 32'h0,        32'h200, 2'd2};
        vecs[6] = '{1'b0, OP_BU, 32'h031, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0,        32'h030, 2'd1};
        vecs[7] = '{1'b0, OP_W,  32'h044, 32'h0,        32'hCAFEF00D, 1, 4'b0000, 32'h0,        32'h044, 2'd0};
        vecs[8] = '{1'b0, OP_B,  32'h052, 32'h0,        32'h00000080, 0, 4'b0000, 32'h0,        32'h050, 2'd2};

        reset = 1'b0; valid_i = 1'b0; we_i = 1'b0; op_i = '0; addr_i = '0; wdata_i = '0;
        flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        repeat (3) @(negedge clk);
        check("rst_req", bus_req_o, 0);
        check("rst_be", bus_be_o, 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_exc", exc_o, 0);
        check("rst_exc_code", exc_code_o, 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Misaligned word load and halfword store.
        @(negedge clk);
        drive(1'b0, OP_W, 32'h101, 32'h0);
`ifdef MEM_ALIGN_EXC_EN
        #1 check("lw_mis_stall", stall_o, 0);
        @(negedge clk);
        valid_i = 1'b0;
        check("lw_mis_exc", exc_o, 1);
        check("lw_mis_code", exc_code_o, EXC_ADEL);
        check("lw_mis_noreq", bus_req_o, 0);
        @(negedge clk);
        drive(1'b1, OP_HU, 32'h303, 32'h00001234);
        @(negedge clk);
        valid_i = 1'b0;
        check("sh_mis_exc", exc_o, 1);
        check("sh_mis_code", exc_code_o, EXC_ADES);
        check("sh_mis_noreq", bus_req_o, 0);
        @(negedge clk);
        check("sh_mis_exc_pulse", exc_o, 0);
`else
        #1 check("lw_mis_stall", stall_o, 1);
        @(negedge clk);
        check("lw_mis_req", bus_req_o, 1);
        check("lw_mis_addr", bus_addr_o, 32'h100);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
        @(negedge clk);
        bus_ack_i = 1'b0; valid_i = 1'b0;
        check("lw_mis_rd_valid", rd_valid_o, 1);
        check("lw_mis_rd_a", rd_a_o, 0);
        check("lw_mis_exc", exc_o, 0);
        @(negedge clk);
        drive(1'b1, OP_HU, 32'h303, 32'h00001234);
        @(negedge clk);
        check("sh_mis_req", bus_req_o, 1);
        check("sh_mis_be", bus_be_o, 4'b1100);
        check("sh_mis_addr", bus_addr_o, 32'h300);
        bus_ack_i = 1'b1;
        @(negedge clk);
        bus_ack_i = 1'b0; valid_i = 1'b0;
        check("sh_mis_exc", exc_o, 0);
`endif

        // Load never acknowledged: timeout after the counter reaches 4.
        @(negedge clk);
        drive(1'b0, OP_W, 32'h400, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("to_req_%0d", i), bus_req_o, 1);
            check($sformatf("to_noexc_%0d", i), exc_o, 0);
            #1 check($sformatf("to_stall_%0d", i), stall_o, 1);
        end
        valid_i = 1'b0;
        @(negedge clk);
        check("to_req_drop", bus_req_o, 0);
        check("to_exc", exc_o, 1);
        check("to_code", exc_code_o, EXC_DBE);
        check("to_stall", stall_o, 0);
        check("to_rd_valid", rd_valid_o, 0);
        @(negedge clk);
        check("to_exc_pulse", exc_o, 0);

        // Ack in the same cycle the counter hits the limit.
        @(negedge clk);
        drive(1'b0, OP_W, 32'h500, 32'h0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        @(negedge clk);
        check("race_req", bus_req_o, 1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h55AA33CC;
        #1 check("race_stall", stall_o, 0);
        @(negedge clk);
        bus_ack_i = 1'b0; valid_i = 1'b0;
        check("race_noexc", exc_o, 0);
        check("race_rd_valid", rd_valid_o, 1);
        check("race_rd_data", rd_data_o, 32'h55AA33CC);
        check("race_req_drop", bus_req_o, 0);

        // Reset during WAIT, then a late ack.
        @(negedge clk);
        drive(1'b0, OP_W, 32'h600, 32'h0);
        @(negedge clk);
        check("rw_req", bus_req_o, 1);
        reset = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        check("rw_req_drop", bus_req_o, 0);
        reset = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF0000;
        #1 check("rw_stall", stall_o, 0);
        @(negedge clk);
        bus_ack_i = 1'b0;
        check("rw_rd_valid", rd_valid_o, 0);
        check("rw_req_idle", bus_req_o, 0);
        check("rw_exc", exc_o, 0);

        // Flush during WAIT: transaction completes, result suppressed.
        @(negedge clk);
        drive(1'b0, OP_W, 32'h700, 32'h0);
        @(negedge clk);
        check("fl_req", bus_req_o, 1);
        flush_i = 1'b1;
        @(negedge clk);
        check("fl_req_kept", bus_req_o, 1);
        flush_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h12121212;
        #1 check("fl_stall", stall_o, 0);
        @(negedge clk);
        bus_ack_i = 1'b0; valid_i = 1'b0;
        check("fl_req_drop", bus_req_o, 0);
        check("fl_rd_valid", rd_valid_o, 0);
        check("fl_exc", exc_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
